// File: rtl/perm_result_buf.sv
// perm_result_buf: captures one NWORDS x 64-bit perm result and serves byte-granular read windows.
// Optional `PERM_BUF_AUTOREL_EN: a read that ends on the last byte of the frame frees the buffer.
module perm_result_buf #(
  parameter int NWORDS = 25,
  parameter int NBYTES = 8*NWORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pushout,
  input  logic        firstout,
  input  logic [63:0] dout,
  output logic        stopout,
  input  logic        rd_req,
  input  logic [7:0]  rd_addr,
  input  logic [7:0]  rd_len,
  input  logic        rd_stall,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        rd_last,
  output logic        buf_full,
  input  logic        buf_release,
  output logic        rd_err,
  output logic        frame_err,
  output logic        ovf_err
);
  localparam logic [1:0] EMPTY = 2'd0, FILL = 2'd1, FULL = 2'd2, READ = 2'd3;
  logic [1:0]  state;
  logic [4:0]  word_cnt;
  logic [7:0]  ptr, rem, ptr_nxt, cur_byte, nxt_byte;
  logic [63:0] mem [NWORDS];
  logic        wr_en, acc, auto_rel;
  logic [4:0]  wr_idx;
  assign wr_en    = pushout & ((state == EMPTY & firstout) | state == FILL);
  assign wr_idx   = firstout ? 5'd0 : word_cnt;
  assign acc      = rd_len != 8'd0 && ({1'b0, rd_addr} + {1'b0, rd_len} <= 9'(NBYTES));
  assign ptr_nxt  = ptr + 8'd1;
  assign cur_byte = mem[ptr[7:3]][{ptr[2:0], 3'b000} +: 8];
  assign nxt_byte = mem[ptr_nxt[7:3]][{ptr_nxt[2:0], 3'b000} +: 8];
`ifdef PERM_BUF_AUTOREL_EN
  assign auto_rel = ptr == 8'(NBYTES-1);
`else
  assign auto_rel = 1'b0;
`endif
  // Frame storage has no reset; its contents are meaningless until a frame completes.
  always_ff @(posedge clk) if (wr_en) mem[wr_idx] <= dout;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      word_cnt  <= 5'd0;
      ptr       <= 8'd0;
      rem       <= 8'd0;
      stopout   <= 1'b1;
      rd_valid  <= 1'b0;
      rd_data   <= 8'd0;
      rd_last   <= 1'b0;
      buf_full  <= 1'b0;
      rd_err    <= 1'b0;
      frame_err <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      rd_err    <= 1'b0;
      frame_err <= 1'b0;
      ovf_err   <= 1'b0;
      case (state)
        EMPTY: begin
          rd_err  <= rd_req;
          stopout <= 1'b0;
          if (pushout && firstout) begin
            word_cnt <= 5'd1;
            state    <= FILL;
          end else frame_err <= pushout;
        end
        FILL: begin
          rd_err <= rd_req;
          if (pushout && firstout) begin
            word_cnt  <= 5'd1;
            frame_err <= 1'b1;
          end else if (pushout && word_cnt == 5'(NWORDS-1)) begin
            word_cnt <= 5'd0;
            state    <= FULL;
            stopout  <= 1'b1;
            buf_full <= 1'b1;
          end else if (pushout) word_cnt <= word_cnt + 5'd1;
        end
        FULL: begin
          ovf_err <= pushout;
          if (buf_release) begin
            state    <= EMPTY;
            stopout  <= 1'b0;
            buf_full <= 1'b0;
          end else if (rd_req && acc) begin
            ptr   <= rd_addr;
            rem   <= rd_len;
            state <= READ;
          end else rd_err <= rd_req;
        end
        default: begin
          ovf_err <= pushout;
          rd_err  <= rd_req;
          // First READ cycle fetches the start byte; afterwards each unstalled edge consumes one.
          if (buf_release || (rd_valid && !rd_stall && rem == 8'd1 && auto_rel)) begin
            state    <= EMPTY;
            stopout  <= 1'b0;
            buf_full <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
          end else if (!rd_valid) begin
            rd_valid <= 1'b1;
            rd_data  <= cur_byte;
            rd_last  <= rem == 8'd1;
          end else if (!rd_stall && rem == 8'd1) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            state    <= FULL;
          end else if (!rd_stall) begin
            ptr     <= ptr_nxt;
            rem     <= rem - 8'd1;
            rd_data <= nxt_byte;
            rd_last <= rem == 8'd2;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_perm_result_buf.sv
// tb_perm_result_buf: random frames and read windows checked against a frame-level reference model.
module tb_perm_result_buf;
  logic        clk = 0, rst, pushout, firstout, rd_req, rd_stall, buf_release;
  logic [63:0] dout;
  logic [7:0]  rd_addr, rd_len, rd_data;
  logic        stopout, rd_valid, rd_last, buf_full, rd_err, frame_err, ovf_err;
  int n_err = 0, n_checks = 0;
  localparam int M_EMPTY = 0, M_FILL = 1, M_FULL = 2;
  int mstate, mcnt;
  logic [63:0] mwords [25];

  perm_result_buf dut (
    .clk(clk), .rst(rst), .pushout(pushout), .firstout(firstout), .dout(dout),
    .stopout(stopout), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_stall(rd_stall), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .buf_full(buf_full), .buf_release(buf_release), .rd_err(rd_err),
    .frame_err(frame_err), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int k);
    return 8'(mwords[k/8] >> (8*(k%8)));
  endfunction

  task automatic check_full(input string tag);
    check({tag, "_buf_full"}, buf_full, mstate == M_FULL);
    check({tag, "_stopout"}, stopout, mstate == M_FULL);
  endtask

  task automatic push(input logic [63:0] w, input logic first);
    bit fe, ovf;
    fe = 0; ovf = 0;
    pushout = 1; firstout = first; dout = w;
    @(negedge clk);
    pushout = 0; firstout = 0;
    if (mstate == M_FULL) ovf = 1;
    else if (first) begin
      fe = (mstate == M_FILL);
      mwords[0] = w; mcnt = 1; mstate = M_FILL;
    end else if (mstate == M_EMPTY) fe = 1;
    else begin
      mwords[mcnt] = w; mcnt++;
      if (mcnt == 25) mstate = M_FULL;
    end
    check("push_frame_err", frame_err, fe);
    check("push_ovf_err", ovf_err, ovf);
    check_full("push");
  endtask

  task automatic fill_frame(input bit pattern);
    for (int i = 0; i < 25; i++)
      push(pattern ? 64'h0706050403020100 + 64'h0808080808080808 * 64'(i) : {$urandom, $urandom}, i == 0);
  endtask

  task automatic release_buf();
    buf_release = 1;
    @(negedge clk);
    buf_release = 0;
    if (mstate == M_FULL) mstate = M_EMPTY;
    check_full("release");
    check("release_rd_valid", rd_valid, 0);
  endtask

  task automatic do_read(input int addr, input int len, input int stall_idx, input int stall_n, input bit rnd);
    bit acc;
    int s;
    acc = mstate == M_FULL && len != 0 && addr + len <= 200;
    rd_req = 1; rd_addr = addr[7:0]; rd_len = len[7:0];
    @(negedge clk);
    rd_req = 0;
    check("rd_err", rd_err, !acc);
    check("rd_valid_first", rd_valid, 0);
    if (acc) begin
      @(negedge clk);
      for (int i = 0; i < len; i++) begin
        s = (i == stall_idx) ? stall_n : (rnd && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        for (int j = 0; j <= s; j++) begin
          check("rd_valid", rd_valid, 1);
          check("rd_data", rd_data, byte_of(addr + i));
          check("rd_last", rd_last, i == len - 1);
          rd_stall = j < s;
          @(negedge clk);
        end
      end
      rd_stall = 0;
`ifdef PERM_BUF_AUTOREL_EN
      if (addr + len == 200) mstate = M_EMPTY;
`endif
      check("rd_done_valid", rd_valid, 0);
      check("rd_done_last", rd_last, 0);
      check_full("rd_done");
    end
  endtask

  initial begin
    rst = 0; pushout = 0; firstout = 0; dout = 0; rd_req = 0; rd_addr = 0; rd_len = 0;
    rd_stall = 0; buf_release = 0; mstate = M_EMPTY; mcnt = 0;
    #12;
    check("rst_stopout", stopout, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_buf_full", buf_full, 0);
    check("rst_errs", {rd_err, frame_err, ovf_err}, 0);
    @(negedge clk); rst = 1;
    @(negedge clk);
    check("empty_stopout", stopout, 0);

    fill_frame(1);
    do_read(0, 200, -1, 0, 0);
    do_read(197, 4, -1, 0, 0);
    do_read(5, 0, -1, 0, 0);
    do_read(16, 3, 1, 2, 0);
    push({$urandom, $urandom}, 1);
    do_read(0, 1, -1, 0, 0);
    release_buf();

    push(64'h1234, 0);
    do_read(0, 4, -1, 0, 0);
    for (int i = 0; i < 10; i++) push({$urandom, $urandom}, i == 0);
    push({$urandom, $urandom}, 1);
    for (int i = 1; i < 25; i++) push({$urandom, $urandom}, 0);
    do_read(0, 200, -1, 0, 1);

    buf_release = 1; rd_req = 1; rd_addr = 0; rd_len = 1;
    pushout = 1; firstout = 1; dout = 64'hdead;
    @(negedge clk);
    buf_release = 0; rd_req = 0; pushout = 0; firstout = 0;
    mstate = M_EMPTY;
    check("relreq_rd_err", rd_err, 0);
    check("relpush_ovf_err", ovf_err, 1);
    check_full("relreq");
    @(negedge clk);
    check("relreq_rd_valid", rd_valid, 0);
    push(64'h5, 0);

    fill_frame(0);
    rd_req = 1; rd_addr = 10; rd_len = 50;
    @(negedge clk); rd_req = 0;
    @(negedge clk);
    check("abort_pre_data", rd_data, byte_of(10));
    buf_release = 1;
    @(negedge clk); buf_release = 0; mstate = M_EMPTY;
    check("abort_rd_valid", rd_valid, 0);
    check("abort_rd_last", rd_last, 0);
    check_full("abort");

    fill_frame(0);
    do_read(192, 8, -1, 0, 0);
    release_buf();

    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 1) == 1)
        for (int i = 0; i < int'($urandom_range(1, 20)); i++) push({$urandom, $urandom}, i == 0);
      fill_frame(0);
      for (int r = 0; r < 4; r++) begin
        int a, l;
        if ($urandom_range(0, 1) == 1) begin
          a = $urandom_range(0, 199); l = $urandom_range(1, 200 - a);
        end else begin
          a = $urandom_range(0, 255); l = $urandom_range(0, 255);
        end
        do_read(a, l, -1, 0, 1);
        if ($urandom_range(0, 3) == 0) push({$urandom, $urandom}, 1'($urandom));
      end
      release_buf();
    end

    fill_frame(0);
    rd_req = 1; rd_addr = 0; rd_len = 100;
    @(negedge clk); rd_req = 0;
    repeat (3) @(negedge clk);
    #2 rst = 0;
    #1;
    mstate = M_EMPTY;
    check("rstmid_rd_valid", rd_valid, 0);
    check("rstmid_rd_data", rd_data, 0);
    check("rstmid_stopout", stopout, 1);
    check("rstmid_buf_full", buf_full, 0);
    @(negedge clk); rst = 1;
    @(negedge clk);
    check_full("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/perm_result_buf.md
Name: perm_result_buf

Overview:
- Output-side stage fed directly by the perm block; consumed by the NoC interface for read responses.
- Captures one 25-word (200-byte) permutation result from the 64-bit pushout/firstout/dout stream, applying stopout backpressure.
- Serves byte-granular read windows to the NoC interface as a registered byte stream with backpressure.

Parameters:
- NWORDS, 25, 64-bit words per result frame.
- NBYTES, 200, bytes per frame (8*NWORDS).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- pushout  in  1  perm word valid.
- firstout  in  1  marks word 0 of a frame (qualified by pushout).
- dout  in  64  perm result word.
- stopout  out  1  backpressure to perm; 1 = do not push.
- rd_req  in  1  read window request, single-cycle pulse.
- rd_addr  in  8  starting byte offset, 0..199.
- rd_len  in  8  byte count, 1..200.
- rd_stall  in  1  consumer not ready; hold current byte.
- rd_valid  out  1  rd_data valid.
- rd_data  out  8  output byte.
- rd_last  out  1  final byte of the window, coincident with rd_valid.
- buf_full  out  1  complete frame held (state FULL or READ).
- buf_release  in  1  frees the buffer.
- rd_err  out  1  one-cycle pulse: rejected rd_req.
- frame_err  out  1  one-cycle pulse: framing violation.
- ovf_err  out  1  one-cycle pulse: pushout while stopout=1.

Behaviour:
- Reset (rst=0, async): state EMPTY, word_cnt=0, stopout=1, rd_valid=0, rd_data=0, rd_last=0, buf_full=0, all error pulses 0. Buffer contents are don't-care.
- All outputs are registered. stopout=0 in EMPTY/FILL and 1 in FULL/READ, updated on the edge that enters the state.
- Byte map: byte k = word[k/8] bits [8*(k%8)+7 : 8*(k%8)] (little-endian within each word).
- EMPTY:
  - pushout&firstout: store word 0, word_cnt=1, go to FILL.
  - pushout without firstout: discard the word and pulse frame_err.
- FILL:
  - pushout&~firstout: store at word_cnt, word_cnt++.
  - Storing word NWORDS-1 goes to FULL; word_cnt wraps to 0.
  - pushout&firstout: restart the frame (store as word 0, word_cnt=1) and pulse frame_err.
- FULL/READ:
  - Any pushout is ignored and pulses ovf_err. No buffer write occurs.
- rd_req acceptance (FULL only):
  - Accepted when rd_len!=0 and rd_addr+rd_len<=200 (9-bit sum). Latch ptr=rd_addr and rem=rd_len, go to READ.
  - Otherwise pulse rd_err and stay in FULL.
  - rd_req in EMPTY/FILL/READ: pulse rd_err, no other effect.
- READ, cycle-level:
  - rd_req accepted at edge N gives rd_valid=1 with byte[rd_addr] after edge N+1.
  - Each edge with rd_valid=1 & rd_stall=0 advances: ptr++, rem--, and the next byte is presented.
  - rd_stall=1 holds rd_data/rd_last stable.
  - rd_last=1 when rem==1. The edge consuming the last byte clears rd_valid and rd_last and returns to FULL.
  - Throughput is 1 byte/cycle when not stalled.
- buf_release:
  - In FULL: go to EMPTY, and stopout=0 next cycle.
  - In READ: abort the read (rd_valid=0, no rd_last) and go to EMPTY.
  - In EMPTY/FILL: ignored.
- Simultaneous events:
  - buf_release and rd_req in the same FULL cycle: release wins, rd_req is dropped silently.
  - pushout&firstout arriving on the edge that FULL is left for EMPTY is ignored (stopout still 1) and pulses ovf_err.
- Reset mid-frame or mid-read aborts immediately to the reset values.

Optional Feature:
- Macro PERM_BUF_AUTOREL_EN.
- Defined: a completed read whose last byte is 199 releases the buffer automatically (READ goes to EMPTY on the last-byte edge; stopout=0 next cycle).
- Not defined: the buffer is freed only by buf_release, and READ always returns to FULL.

Test Plan:
- Reset, then 25 pushes of dout=0x0706050403020100+0x0808080808080808*i with firstout on i=0 -> buf_full=1, stopout=1 one cycle after word 24 is stored.
- Full buffer, rd_req addr=0 len=200, no stall -> 200 consecutive bytes 0x00..0xC7 with rd_last on 0xC7, then state FULL.
- rd_req addr=197 len=4 -> rd_err pulse, no rd_valid. rd_req addr=5 len=0 -> rd_err pulse.
- rd_req addr=16 len=3 with rd_stall=1 for 2 cycles on the second byte -> bytes 0x10,0x11,0x11,0x11,0x12, with data held during the stall and rd_last on 0x12.
- Mid-fill (10 words), then pushout with firstout -> frame_err pulse and word_cnt=1. Push while FULL -> ovf_err pulse, with the rd_addr=0 byte unchanged.
- With PERM_BUF_AUTOREL_EN: read addr=192 len=8 -> after rd_last, buf_full=0 and stopout=0. Without the macro: buf_full stays 1.
